// File: rtl/key_pkg.sv
// Shared definitions for the push-button pulse generator.
// Holds the per-button FSM state encoding, the counter widths and the
// number of button channels used by key_pulse_gen and key_channel.
package key_pkg;

    localparam int NUM_KEYS  = 4;
    // Debounce counter must hold DEB_TICKS values up to 15.
    localparam int DEB_CNT_W = 4;
    // Auto-repeat counter must hold REP_DELAY / REP_RATE.
    localparam int REP_CNT_W = 16;

    typedef enum logic [1:0] {
        KEY_IDLE   = 2'd0,
        KEY_ARM    = 2'd1,
        KEY_HELD   = 2'd2,
        KEY_DISARM = 2'd3
    } key_state_e;

endpackage

// File: rtl/key_channel.sv
// Single-button debounce FSM (IDLE / ARM / HELD / DISARM).
// State only advances in cycles where tick is high. With KEY_REPEAT_EN
// defined, a held button also produces auto-repeat pulses.
// Ports:
//   CLK    - system clock
//   RST    - synchronous active-high reset
//   tick   - one-cycle sample strobe from the shared prescaler
//   synced - synchronised button level (1 = pressed)
//   level  - debounced level, registered (1 in HELD / DISARM)
//   press  - one-cycle pulse after the tick that accepts a press
//            (plus auto-repeat pulses when KEY_REPEAT_EN is defined)
module key_channel
    import key_pkg::*;
#(
    parameter int DEB_TICKS = 4
`ifdef KEY_REPEAT_EN
    ,
    parameter int REP_DELAY = 250,
    parameter int REP_RATE  = 60
`endif
)(
    input  logic CLK,
    input  logic RST,
    input  logic tick,
    input  logic synced,
    output logic level,
    output logic press
);

    localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_TICKS);

    key_state_e           state_r;
    logic [DEB_CNT_W-1:0] deb_cnt_r;
    logic [DEB_CNT_W-1:0] deb_cnt_inc_s;
    logic                 deb_done_s;
    logic                 rep_fire_s;

    assign deb_cnt_inc_s = deb_cnt_r + DEB_CNT_W'(1);
    assign deb_done_s    = (deb_cnt_inc_s == DEB_LAST);

`ifdef KEY_REPEAT_EN
    localparam logic [REP_CNT_W-1:0] REP_DELAY_V = REP_CNT_W'(REP_DELAY);
    localparam logic [REP_CNT_W-1:0] REP_RATE_V  = REP_CNT_W'(REP_RATE);

    logic [REP_CNT_W-1:0] rep_cnt_r;
    logic [REP_CNT_W-1:0] rep_cnt_inc_s;
    logic                 rep_first_done_r;

    assign rep_cnt_inc_s = rep_cnt_r + REP_CNT_W'(1);

    // Repeat fires on the tick that completes the initial delay, then each rate period.
    always_comb begin
        rep_fire_s = 1'b0;
        if (tick && (state_r == KEY_HELD) && synced) begin
            if (rep_first_done_r) begin
                rep_fire_s = (rep_cnt_inc_s == REP_RATE_V);
            end else begin
                rep_fire_s = (rep_cnt_inc_s == REP_DELAY_V);
            end
        end else begin
            rep_fire_s = 1'b0;
        end
    end

    // Repeat counter: advances per tick while staying in HELD, clears otherwise,
    // so both ARM->HELD and DISARM->HELD entries start from zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rep_cnt_r        <= '0;
            rep_first_done_r <= 1'b0;
        end else if (tick) begin
            if ((state_r == KEY_HELD) && synced) begin
                if (rep_fire_s) begin
                    rep_cnt_r        <= '0;
                    rep_first_done_r <= 1'b1;
                end else begin
                    rep_cnt_r        <= rep_cnt_inc_s;
                    rep_first_done_r <= rep_first_done_r;
                end
            end else begin
                rep_cnt_r        <= '0;
                rep_first_done_r <= 1'b0;
            end
        end else begin
            rep_cnt_r        <= rep_cnt_r;
            rep_first_done_r <= rep_first_done_r;
        end
    end
`else
    assign rep_fire_s = 1'b0;
`endif

    // Debounce FSM with registered level and press outputs.
    // press is cleared every cycle unless a tick sets it, giving a one-cycle pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= KEY_IDLE;
            deb_cnt_r <= '0;
            level     <= 1'b0;
            press     <= 1'b0;
        end else if (tick) begin
            press <= 1'b0;
            case (state_r)
                KEY_IDLE: begin
                    if (synced) begin
                        // A single-tick debounce accepts the press immediately.
                        if (DEB_TICKS == 1) begin
                            state_r   <= KEY_HELD;
                            deb_cnt_r <= '0;
                            level     <= 1'b1;
                            press     <= 1'b1;
                        end else begin
                            state_r   <= KEY_ARM;
                            deb_cnt_r <= DEB_CNT_W'(1);
                            level     <= 1'b0;
                        end
                    end else begin
                        state_r   <= KEY_IDLE;
                        deb_cnt_r <= '0;
                        level     <= 1'b0;
                    end
                end
                KEY_ARM: begin
                    if (!synced) begin
                        state_r   <= KEY_IDLE;
                        deb_cnt_r <= '0;
                        level     <= 1'b0;
                    end else if (deb_done_s) begin
                        state_r   <= KEY_HELD;
                        deb_cnt_r <= '0;
                        level     <= 1'b1;
                        press     <= 1'b1;
                    end else begin
                        state_r   <= KEY_ARM;
                        deb_cnt_r <= deb_cnt_inc_s;
                        level     <= 1'b0;
                    end
                end
                KEY_HELD: begin
                    if (!synced) begin
                        if (DEB_TICKS == 1) begin
                            state_r   <= KEY_IDLE;
                            deb_cnt_r <= '0;
                            level     <= 1'b0;
                        end else begin
                            state_r   <= KEY_DISARM;
                            deb_cnt_r <= DEB_CNT_W'(1);
                            level     <= 1'b1;
                        end
                    end else begin
                        state_r   <= KEY_HELD;
                        deb_cnt_r <= '0;
                        level     <= 1'b1;
                        press     <= rep_fire_s;
                    end
                end
                KEY_DISARM: begin
                    if (synced) begin
                        // Release was a glitch: back to HELD without a new pulse.
                        state_r   <= KEY_HELD;
                        deb_cnt_r <= '0;
                        level     <= 1'b1;
                    end else if (deb_done_s) begin
                        state_r   <= KEY_IDLE;
                        deb_cnt_r <= '0;
                        level     <= 1'b0;
                    end else begin
                        state_r   <= KEY_DISARM;
                        deb_cnt_r <= deb_cnt_inc_s;
                        level     <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= KEY_IDLE;
                    deb_cnt_r <= '0;
                    level     <= 1'b0;
                end
            endcase
        end else begin
            state_r   <= state_r;
            deb_cnt_r <= deb_cnt_r;
            level     <= level;
            press     <= 1'b0;
        end
    end

endmodule

// File: rtl/key_pulse_gen.sv
// Push-button pulse generator: synchronises NUM_KEYS raw button inputs,
// produces a shared sample tick and debounces each button into a level
// and a one-cycle press pulse. Optional macro KEY_REPEAT_EN enables
// auto-repeat pulses while a button is held.
// Ports:
//   CLK   - system clock
//   RST   - synchronous active-high reset
//   PUSH  - raw asynchronous button levels (1 = pressed)
//   LEVEL - debounced button levels, registered
//   PRESS - one-cycle press pulses, registered
//   TICK  - one-cycle sample strobe every TICK_DIV+1 cycles, registered
module key_pulse_gen
    import key_pkg::*;
#(
    parameter int TICK_DIV  = 2000,
    parameter int DEB_TICKS = 4,
    parameter int REP_DELAY = 250,
    parameter int REP_RATE  = 60
)(
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_KEYS-1:0] PUSH,
    output logic [NUM_KEYS-1:0] LEVEL,
    output logic [NUM_KEYS-1:0] PRESS,
    output logic                TICK
);

    localparam int PRESC_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV);

    // Reject configurations the counters cannot represent.
    if ((DEB_TICKS < 1) || (DEB_TICKS > 15) || (TICK_DIV < 0) ||
        (REP_DELAY < 1) || (REP_DELAY > 65535) ||
        (REP_RATE < 1) || (REP_RATE > 65535)) begin : g_bad_cfg
        $error("key_pulse_gen: parameter out of range");
    end

    logic [PRESC_W-1:0]  presc_r;
    logic [PRESC_W-1:0]  presc_next_s;
    logic                tick_r;
    logic [NUM_KEYS-1:0] push_meta_r;
    logic [NUM_KEYS-1:0] push_sync_r;

    // Prescaler wrap: counts 0..TICK_DIV.
    always_comb begin
        presc_next_s = '0;
        if (presc_r == PRESC_MAX) begin
            presc_next_s = '0;
        end else begin
            presc_next_s = presc_r + PRESC_W'(1);
        end
    end

    // Prescaler and tick strobe; tick_r is high while the count sits at TICK_DIV.
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_r <= '0;
            tick_r  <= 1'b0;
        end else begin
            presc_r <= presc_next_s;
            tick_r  <= (presc_next_s == PRESC_MAX);
        end
    end

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            push_meta_r <= '0;
            push_sync_r <= '0;
        end else begin
            push_meta_r <= PUSH;
            push_sync_r <= push_meta_r;
        end
    end

    assign TICK = tick_r;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_channel #(
            .DEB_TICKS (DEB_TICKS)
`ifdef KEY_REPEAT_EN
            ,
            .REP_DELAY (REP_DELAY),
            .REP_RATE  (REP_RATE)
`endif
        ) u_chan (
            .CLK    (CLK),
            .RST    (RST),
            .tick   (tick_r),
            .synced (push_sync_r[gi]),
            .level  (LEVEL[gi]),
            .press  (PRESS[gi])
        );
    end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Self-checking bench for key_pulse_gen with TICK_DIV=3, DEB_TICKS=2,
// REP_DELAY=3, REP_RATE=2. A behavioural model (run-length debounce plus
// hold-age repeat arithmetic) is compared every cycle; directed scenarios
// add hand-computed timing and pulse-count expectations.
module tb_key_pulse_gen;

    localparam int TICK_DIV  = 3;
    localparam int DEB_TICKS = 2;
    localparam int REP_DELAY = 3;
    localparam int REP_RATE  = 2;
`ifdef KEY_REPEAT_EN
    localparam int REP_PULSES = 5;
`else
    localparam int REP_PULSES = 1;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] PUSH;
    logic [3:0] LEVEL;
    logic [3:0] PRESS;
    logic       TICK;

    int checks = 0;
    int errors = 0;
    int press_tot [4];
    int base [4];

    always #5 CLK = ~CLK;

    key_pulse_gen #(
        .TICK_DIV  (TICK_DIV),
        .DEB_TICKS (DEB_TICKS),
        .REP_DELAY (REP_DELAY),
        .REP_RATE  (REP_RATE)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .PUSH  (PUSH),
        .LEVEL (LEVEL),
        .PRESS (PRESS),
        .TICK  (TICK)
    );

    // ---------------- behavioural model ----------------
    // Level flips once DEB_TICKS consecutive tick samples disagree with it;
    // hold age counts ticks spent continuously held since the last entry.
    bit         m_valid = 1'b0;
    int         m_cnt;
    bit         m_tick;
    logic [3:0] m_s1, m_s2, m_level, m_press, m_last;
    int         m_run [4];
    int         m_age [4];

    always @(posedge CLK) begin
        if (RST === 1'b1) begin
            m_valid = 1'b1;
            m_cnt = 0; m_tick = 1'b0;
            m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_last = '0;
            for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_age[i] = 0; end
        end else begin
            m_press = '0;
            if (m_tick) begin
                for (int i = 0; i < 4; i++) begin
                    logic smp;
                    bit   was_held;
                    smp = m_s2[i];
                    was_held = m_level[i] && m_last[i];
                    if (smp == m_last[i]) m_run[i] = m_run[i] + 1;
                    else m_run[i] = 1;
                    if ((m_run[i] >= DEB_TICKS) && (m_level[i] != smp)) begin
                        m_level[i] = smp;
                        if (smp) m_press[i] = 1'b1;
                    end
                    if (m_level[i] && smp) begin
                        if (was_held) begin
                            m_age[i] = m_age[i] + 1;
`ifdef KEY_REPEAT_EN
                            if ((m_age[i] >= REP_DELAY) && (((m_age[i] - REP_DELAY) % REP_RATE) == 0))
                                m_press[i] = 1'b1;
`endif
                        end else begin
                            m_age[i] = 0;
                        end
                    end
                    m_last[i] = smp;
                end
            end
            m_s2 = m_s1;
            m_s1 = PUSH;
            m_cnt = (m_cnt == TICK_DIV) ? 0 : m_cnt + 1;
            m_tick = (m_cnt == TICK_DIV);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int k = 0; (k < 16) && !seen; k++) begin
            @(negedge CLK);
            if (TICK === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            errors++;
            $display("FAIL tick_timeout: got no TICK in 16 cycles, required one");
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) base[i] = press_tot[i];
    endtask

    // ---------------- monitor + stimulus ----------------
    initial begin
        for (int i = 0; i < 4; i++) press_tot[i] = 0;
        $display("tb_key_pulse_gen: TICK_DIV=%0d DEB_TICKS=%0d REP_DELAY=%0d REP_RATE=%0d",
                 TICK_DIV, DEB_TICKS, REP_DELAY, REP_RATE);
        fork
            begin : monitor
                forever begin
                    @(negedge CLK);
                    if (m_valid) begin
                        check("model_tick",  {3'b000, TICK}, {3'b000, m_tick});
                        check("model_level", LEVEL, m_level);
                        check("model_press", PRESS, m_press);
                    end
                    for (int i = 0; i < 4; i++)
                        if (PRESS[i] === 1'b1) press_tot[i] = press_tot[i] + 1;
                end
            end
            begin : stimulus
                bit hi_seen;
                bit low_seen;
                RST = 1'b1;
                PUSH = 4'b0000;
                repeat (3) @(negedge CLK);
                check("reset_level", LEVEL, 4'b0000);
                check("reset_press", PRESS, 4'b0000);
                check("reset_tick", {3'b000, TICK}, 4'b0000);
                RST = 1'b0;

                // Clean press on button 0: pulse 9 negedges after driving at a tick.
                wait_tick();
                PUSH = 4'b0001;
                snap();
                repeat (8) @(negedge CLK);
                check("clean_press_early", PRESS, 4'b0000);
                check("clean_level_early", LEVEL, 4'b0000);
                @(negedge CLK);
                check("clean_press", PRESS, 4'b0001);
                check("clean_level", LEVEL, 4'b0001);
                @(negedge CLK);
                check("clean_press_width", PRESS, 4'b0000);
                wait_tick();
                PUSH = 4'b0000;
                repeat (6) wait_tick();
                check_int("clean_count0", press_tot[0] - base[0], 1);

                // Bounce on button 1: one tick high, one tick low, five times.
                snap();
                hi_seen = 1'b0;
                wait_tick();
                for (int r = 0; r < 5; r++) begin
                    PUSH = 4'b0010;
                    repeat (4) begin
                        @(negedge CLK);
                        if ((LEVEL[1] === 1'b1) || (PRESS[1] === 1'b1)) hi_seen = 1'b1;
                    end
                    PUSH = 4'b0000;
                    repeat (4) begin
                        @(negedge CLK);
                        if ((LEVEL[1] === 1'b1) || (PRESS[1] === 1'b1)) hi_seen = 1'b1;
                    end
                end
                repeat (3) wait_tick();
                check("bounce_quiet", {3'b000, hi_seen}, 4'b0000);
                check_int("bounce_count1", press_tot[1] - base[1], 0);

                // Simultaneous press and release of all buttons.
                wait_tick();
                PUSH = 4'b1111;
                snap();
                repeat (8) @(negedge CLK);
                check("simul_press_early", PRESS, 4'b0000);
                @(negedge CLK);
                check("simul_press", PRESS, 4'b1111);
                check("simul_level", LEVEL, 4'b1111);
                wait_tick();
                PUSH = 4'b0000;
                repeat (8) @(negedge CLK);
                check("simul_release_early", LEVEL, 4'b1111);
                @(negedge CLK);
                check("simul_release", LEVEL, 4'b0000);
                repeat (4) wait_tick();
                for (int i = 0; i < 4; i++)
                    check_int("simul_count", press_tot[i] - base[i], 1);

                // Reset while held: outputs clear, then a fresh debounce.
                wait_tick();
                PUSH = 4'b0001;
                repeat (12) @(negedge CLK);
                check("pre_reset_level", LEVEL, 4'b0001);
                RST = 1'b1;
                @(negedge CLK);
                check("rst_level", LEVEL, 4'b0000);
                check("rst_press", PRESS, 4'b0000);
                check("rst_tick", {3'b000, TICK}, 4'b0000);
                RST = 1'b0;
                repeat (7) @(negedge CLK);
                check("rst_repress_early", PRESS, 4'b0000);
                @(negedge CLK);
                check("rst_repress", PRESS, 4'b0001);
                wait_tick();
                PUSH = 4'b0000;
                repeat (4) wait_tick();

                // Long hold on button 2: repeats at +3,+5,+7,+9 ticks when enabled.
                wait_tick();
                PUSH = 4'b0100;
                snap();
                repeat (9) @(negedge CLK);
                check("rep_first", PRESS, 4'b0100);
                repeat (10) wait_tick();
                PUSH = 4'b0000;
                repeat (6) wait_tick();
                check_int("rep_count2", press_tot[2] - base[2], REP_PULSES);

                // One-tick glitch low on held button 3.
                wait_tick();
                PUSH = 4'b1000;
                snap();
                repeat (9) @(negedge CLK);
                check("glitch_first", PRESS, 4'b1000);
                wait_tick();
                PUSH = 4'b0000;
                low_seen = 1'b0;
                repeat (4) begin
                    @(negedge CLK);
                    if (LEVEL[3] !== 1'b1) low_seen = 1'b1;
                end
                PUSH = 4'b1000;
                repeat (8) begin
                    @(negedge CLK);
                    if (LEVEL[3] !== 1'b1) low_seen = 1'b1;
                end
                PUSH = 4'b0000;
                check("glitch_level_held", {3'b000, low_seen}, 4'b0000);
                repeat (5) wait_tick();
                check_int("glitch_count3", press_tot[3] - base[3], 1);
                check("final_level", LEVEL, 4'b0000);
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
